// File: rtl/meas_sequencer_pkg.sv
// Shared types and codes for the measurement sequencer: FSM states, run mode
// and the method_state encoding reported to the front panel.
package meas_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SWEEP  = 1'b1
    } mode_t;

    localparam logic [1:0] METHOD_IDLE   = 2'b00;
    localparam logic [1:0] METHOD_SINGLE = 2'b10;
    localparam logic [1:0] METHOD_SWEEP  = 2'b11;

    function automatic logic [1:0] method_code(mode_t m);
        return (m == MODE_SWEEP) ? METHOD_SWEEP : METHOD_SINGLE;
    endfunction

endpackage

// File: rtl/meas_sequencer_if.sv
// DDS-side handshake: the sequencer presents a table address with a launch
// pulse and receives the per-point completion pulse from the UART sender.
interface meas_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] addr;
    logic              valid_dds;
    logic              end_send_uart;

    modport master (output addr, output valid_dds, input end_send_uart);
    modport slave  (input addr, input valid_dds, output end_send_uart);
endinterface

// File: rtl/meas_sequencer_point_list.sv
// Point list for single-list mode: register file with one synchronous write
// port and one combinational read port, cleared on reset.
module seq_point_list #(
    parameter int ADDR_W     = 6,
    parameter int LIST_DEPTH = 8,
    localparam int IDX_W     = $clog2(LIST_DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [ADDR_W-1:0] rdata_o
);

    logic [ADDR_W-1:0] mem_q [LIST_DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LIST_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write is not seen by the read, so a launched point never changes.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: steps DDS table addresses through a programmable
// list or a first..last sweep, one launch per point, with timeout retry.
module meas_sequencer
    import meas_seq_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int LIST_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50_000_000,
    localparam int IDX_W      = $clog2(LIST_DEPTH),
    localparam int LEN_W      = IDX_W + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               key_single,
    input  logic               key_sweep,
    input  logic               key_stop,
    input  logic               cont_en,
    input  logic [LEN_W-1:0]   list_len,
    input  logic               list_we,
    input  logic [IDX_W-1:0]   list_waddr,
    input  logic [ADDR_W-1:0]  list_wdata,
    input  logic [ADDR_W-1:0]  sweep_first,
    input  logic [ADDR_W-1:0]  sweep_last,
    meas_sequencer_if.master   dds,
    output logic [1:0]         method_state,
    output logic               busy,
    output logic               sweep_done,
    output logic               timeout_flag
);

    localparam int          CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TLIM  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TLIM);
    localparam bit          TO_EN = (TIMEOUT_CYC > 0);

    function automatic logic [LEN_W-1:0] clamp_len(logic [LEN_W-1:0] l);
        if (l == '0)                     return LEN_W'(1);
        if (l > LEN_W'(LIST_DEPTH))      return LEN_W'(LIST_DEPTH);
        return l;
    endfunction

    state_t            state_q;
    mode_t             mode_q;
    logic [ADDR_W-1:0] addr_q, first_q, last_q;
    logic              asc_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  tcnt_q;
    logic              valid_q, done_q, tflag_q, busy_q;
    logic [1:0]        method_q;

    logic              start_single;
    logic [LEN_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  raddr;
    logic [ADDR_W-1:0] list_rdata;
    logic              timeout_hit;

    assign start_single = key_single & ~key_sweep & ~key_stop;
    assign idx_inc      = {1'b0, idx_q} + LEN_W'(1);
    assign idx_next     = (idx_inc >= len_q) ? '0 : idx_inc[IDX_W-1:0];
    assign raddr        = start_single ? '0 : idx_next;
    assign timeout_hit  = TO_EN && (tcnt_q == TMAX);

    seq_point_list #(
        .ADDR_W     (ADDR_W),
        .LIST_DEPTH (LIST_DEPTH)
    ) u_list (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (list_we),
        .waddr_i (list_waddr),
        .wdata_i (list_wdata),
        .raddr_i (raddr),
        .rdata_o (list_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SINGLE;
            addr_q   <= '0;
            first_q  <= '0;
            last_q   <= '0;
            asc_q    <= 1'b1;
            idx_q    <= '0;
            len_q    <= LEN_W'(1);
            tcnt_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            tflag_q  <= 1'b0;
            busy_q   <= 1'b0;
            method_q <= METHOD_IDLE;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            // Keys take priority over anything the current state would do.
            if (key_stop) begin
                if (state_q != ST_IDLE) begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    method_q <= METHOD_IDLE;
                end
            end else if (key_sweep) begin
                first_q  <= sweep_first;
                last_q   <= sweep_last;
                asc_q    <= (sweep_first <= sweep_last);
                addr_q   <= sweep_first;
                mode_q   <= MODE_SWEEP;
                state_q  <= ST_LAUNCH;
                valid_q  <= 1'b1;
                tcnt_q   <= '0;
                tflag_q  <= 1'b0;
                busy_q   <= 1'b1;
                method_q <= METHOD_SWEEP;
            end else if (key_single) begin
                len_q    <= clamp_len(list_len);
                idx_q    <= '0;
                addr_q   <= list_rdata;
                mode_q   <= MODE_SINGLE;
                state_q  <= ST_LAUNCH;
                valid_q  <= 1'b1;
                tcnt_q   <= '0;
                tflag_q  <= 1'b0;
                busy_q   <= 1'b1;
                method_q <= METHOD_SINGLE;
            end else begin
                case (state_q)
                    ST_LAUNCH: begin
                        tcnt_q  <= '0;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (dds.end_send_uart) begin
                            if (mode_q == MODE_SINGLE) begin
                                idx_q   <= idx_next;
                                addr_q  <= list_rdata;
                                state_q <= ST_LAUNCH;
                                valid_q <= 1'b1;
                            end else if (addr_q == last_q) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q  <= asc_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
                                state_q <= ST_LAUNCH;
                                valid_q <= 1'b1;
                            end
                        end else if (timeout_hit) begin
                            tflag_q <= 1'b1;
                            state_q <= ST_LAUNCH;
                            valid_q <= 1'b1;
                        end else begin
                            tcnt_q <= tcnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (cont_en) begin
                            addr_q  <= first_q;
                            state_q <= ST_LAUNCH;
                            valid_q <= 1'b1;
                        end else begin
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                            method_q <= METHOD_IDLE;
                        end
                    end
                    default: begin
                        method_q <= METHOD_IDLE;
                    end
                endcase
            end
        end
    end

    assign dds.addr      = addr_q;
    assign dds.valid_dds = valid_q;
    assign method_state  = method_q;
    assign busy          = busy_q;
    assign sweep_done    = done_q;
    assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer: a table of sweep/list runs plus
// hand-written sequences for the full sweep, timeout, key races and reset.
module tb_meas_sequencer;

    localparam int AW = 6;
    localparam int LD = 8;
    localparam int TO = 20;

    typedef struct {
        int is_sweep;
        int first;
        int last;
        int len;
        int cont;
        int n;
        int done_at;
        int end_idle;
        int meth;
        int exp[10];
    } row_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          key_single = 1'b0, key_sweep = 1'b0, key_stop = 1'b0, cont_en = 1'b0;
    logic [3:0]    list_len = '0;
    logic          list_we = 1'b0;
    logic [2:0]    list_waddr = '0;
    logic [AW-1:0] list_wdata = '0, sweep_first = '0, sweep_last = '0;
    logic [1:0]    method_state;
    logic          busy, sweep_done, timeout_flag;

    int checks = 0;
    int failures = 0;
    int vcount = 0;
    int dcount = 0;
    row_t rows[9];

    meas_sequencer_if #(.ADDR_W(AW)) dds();

    meas_sequencer #(
        .ADDR_W(AW), .LIST_DEPTH(LD), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .key_single(key_single), .key_sweep(key_sweep), .key_stop(key_stop),
        .cont_en(cont_en), .list_len(list_len),
        .list_we(list_we), .list_waddr(list_waddr), .list_wdata(list_wdata),
        .sweep_first(sweep_first), .sweep_last(sweep_last),
        .dds(dds),
        .method_state(method_state), .busy(busy),
        .sweep_done(sweep_done), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dds.valid_dds) vcount <= vcount + 1;
        if (sweep_done)    dcount <= dcount + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!dds.valid_dds && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(dds.valid_dds), 1);
    endtask

    task automatic write_list(input int idx, input int val);
        list_we = 1'b1;
        list_waddr = 3'(idx);
        list_wdata = AW'(val);
        @(negedge clk);
        list_we = 1'b0;
    endtask

    task automatic pulse_end();
        dds.end_send_uart = 1'b1;
        @(negedge clk);
        dds.end_send_uart = 1'b0;
    endtask

    task automatic set_row(input int i, input int sw, input int f, input int l, input int len,
                           input int c, input int n, input int da, input int ei, input int m);
        rows[i].is_sweep = sw; rows[i].first = f; rows[i].last = l; rows[i].len = len;
        rows[i].cont = c; rows[i].n = n; rows[i].done_at = da; rows[i].end_idle = ei;
        rows[i].meth = m;
    endtask

    task automatic stop_and_idle(input string nm);
        int v0;
        key_stop = 1'b1;
        @(negedge clk);
        key_stop = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_meth"}, 32'(method_state), 0);
        chk({nm, "_vld"}, 32'(dds.valid_dds), 0);
        v0 = vcount;
        repeat (20) @(negedge clk);
        chk({nm, "_novld"}, 32'(vcount - v0), 0);
    endtask

    task automatic run_row(input int ri);
        row_t r;
        r = rows[ri];
        if (r.is_sweep != 0) begin
            sweep_first = AW'(r.first);
            sweep_last  = AW'(r.last);
            cont_en     = (r.cont != 0);
            key_sweep   = 1'b1;
        end else begin
            cont_en    = 1'b0;
            list_len   = 4'(r.len);
            key_single = 1'b1;
        end
        @(negedge clk);
        key_sweep  = 1'b0;
        key_single = 1'b0;
        for (int i = 0; i < r.n; i++) begin
            chk($sformatf("row%0d_vld%0d", ri, i), 32'(dds.valid_dds), 1);
            chk($sformatf("row%0d_addr%0d", ri, i), 32'(dds.addr), 32'(r.exp[i]));
            chk($sformatf("row%0d_meth%0d", ri, i), 32'(method_state), 32'(r.meth));
            @(negedge clk);
            chk($sformatf("row%0d_pulse%0d", ri, i), 32'(dds.valid_dds), 0);
            if (i < r.n - 1 || i == r.done_at) begin
                pulse_end();
                if (i == r.done_at) begin
                    chk($sformatf("row%0d_done", ri), 32'(sweep_done), 1);
                    chk($sformatf("row%0d_donevld", ri), 32'(dds.valid_dds), 0);
                    @(negedge clk);
                end
            end
        end
        if (r.end_idle != 0) begin
            chk($sformatf("row%0d_idle_busy", ri), 32'(busy), 0);
            chk($sformatf("row%0d_idle_meth", ri), 32'(method_state), 0);
        end
        stop_and_idle($sformatf("row%0d_stop", ri));
    endtask

    initial begin
        int v0, d0, n;
        dds.end_send_uart = 1'b0;

        set_row(0, 1, 10,  7, 0, 1, 5,  3, 0, 3); rows[0].exp = '{10, 9, 8, 7, 10, 0, 0, 0, 0, 0};
        set_row(1, 1,  3,  5, 0, 0, 3,  2, 1, 3); rows[1].exp = '{3, 4, 5, 0, 0, 0, 0, 0, 0, 0};
        set_row(2, 1,  9,  9, 0, 0, 1,  0, 1, 3); rows[2].exp = '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_row(3, 0,  0,  0, 4, 0, 10, -1, 0, 2); rows[3].exp = '{10, 18, 22, 27, 10, 18, 22, 27, 10, 18};
        set_row(4, 0,  0,  0, 0, 0, 3, -1, 0, 2); rows[4].exp = '{10, 10, 10, 0, 0, 0, 0, 0, 0, 0};
        set_row(5, 0,  0,  0, 15, 0, 9, -1, 0, 2); rows[5].exp = '{10, 18, 22, 27, 30, 31, 32, 33, 10, 0};
        set_row(6, 0,  0,  0, 3, 0, 4, -1, 0, 2); rows[6].exp = '{10, 18, 22, 10, 0, 0, 0, 0, 0, 0};
        set_row(7, 1, 63, 61, 0, 0, 3,  2, 1, 3); rows[7].exp = '{63, 62, 61, 0, 0, 0, 0, 0, 0, 0};
        set_row(8, 1,  0,  1, 0, 1, 3,  1, 0, 3); rows[8].exp = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(dds.addr), 0);
        chk("rst_vld", 32'(dds.valid_dds), 0);
        chk("rst_meth", 32'(method_state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(sweep_done), 0);
        chk("rst_tflag", 32'(timeout_flag), 0);
        rstn = 1'b1;
        @(negedge clk);

        write_list(0, 10); write_list(1, 18); write_list(2, 22); write_list(3, 27);
        write_list(4, 30); write_list(5, 31); write_list(6, 32); write_list(7, 33);

        for (int ri = 0; ri < 9; ri++) run_row(ri);

        // Full 0..36 sweep, completion 5 cycles after each launch
        sweep_first = 6'd0; sweep_last = 6'd36; cont_en = 1'b0;
        v0 = vcount; d0 = dcount;
        key_sweep = 1'b1;
        @(negedge clk);
        key_sweep = 1'b0;
        for (int i = 0; i < 37; i++) begin
            wait_valid($sformatf("sw37_vld%0d", i), 50);
            chk($sformatf("sw37_addr%0d", i), 32'(dds.addr), 32'(i));
            repeat (4) @(negedge clk);
            pulse_end();
        end
        chk("sw37_done", 32'(sweep_done), 1);
        @(negedge clk);
        chk("sw37_busy", 32'(busy), 0);
        chk("sw37_meth", 32'(method_state), 0);
        repeat (3) @(negedge clk);
        chk("sw37_npulses", 32'(vcount - v0), 37);
        chk("sw37_ndone", 32'(dcount - d0), 1);

        // Timeout retry with no completion
        list_len = 4'd1;
        key_single = 1'b1;
        @(negedge clk);
        key_single = 1'b0;
        chk("to_first_addr", 32'(dds.addr), 10);
        chk("to_flag0", 32'(timeout_flag), 0);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!dds.valid_dds && n < 40);
            chk($sformatf("to_period%0d", k), 32'(n), 21);
            chk($sformatf("to_addr%0d", k), 32'(dds.addr), 10);
            chk($sformatf("to_flag%0d", k + 1), 32'(timeout_flag), 1);
        end
        sweep_first = 6'd5; sweep_last = 6'd9; cont_en = 1'b0;
        key_sweep = 1'b1;
        @(negedge clk);
        key_sweep = 1'b0;
        chk("to_clear", 32'(timeout_flag), 0);
        chk("to_sw_addr", 32'(dds.addr), 5);

        // Completion and key_single in the same cycle during a sweep
        @(negedge clk);
        pulse_end();
        chk("race_sw_addr", 32'(dds.addr), 6);
        @(negedge clk);
        list_len = 4'd4;
        dds.end_send_uart = 1'b1;
        key_single = 1'b1;
        @(negedge clk);
        dds.end_send_uart = 1'b0;
        key_single = 1'b0;
        chk("race_vld", 32'(dds.valid_dds), 1);
        chk("race_addr", 32'(dds.addr), 10);
        chk("race_meth", 32'(method_state), 2);
        chk("race_nodone", 32'(sweep_done), 0);
        @(negedge clk);
        pulse_end();
        chk("race_next", 32'(dds.addr), 18);
        // Completion during the launch cycle is ignored
        pulse_end();
        chk("launch_end_vld", 32'(dds.valid_dds), 0);
        chk("launch_end_addr", 32'(dds.addr), 18);
        repeat (3) @(negedge clk);
        chk("launch_end_wait", 32'(dds.valid_dds), 0);
        chk("launch_end_busy", 32'(busy), 1);
        stop_and_idle("race_stop");

        // Completion in IDLE is ignored
        pulse_end();
        chk("idle_end_busy", 32'(busy), 0);
        chk("idle_end_vld", 32'(dds.valid_dds), 0);

        // Asynchronous reset while waiting, with the timeout flag set
        list_len = 4'd1;
        key_single = 1'b1;
        @(negedge clk);
        key_single = 1'b0;
        repeat (22) @(negedge clk);
        chk("pre_rst_flag", 32'(timeout_flag), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_addr", 32'(dds.addr), 0);
        chk("arst_vld", 32'(dds.valid_dds), 0);
        chk("arst_meth", 32'(method_state), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_flag", 32'(timeout_flag), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        list_len = 4'd0;
        key_single = 1'b1;
        @(negedge clk);
        key_single = 1'b0;
        chk("post_rst_vld", 32'(dds.valid_dds), 1);
        chk("post_rst_list0", 32'(dds.addr), 0);
        @(negedge clk);
        pulse_end();
        chk("post_rst_rep_vld", 32'(dds.valid_dds), 1);
        chk("post_rst_rep_addr", 32'(dds.addr), 0);
        stop_and_idle("final_stop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
